// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16 requesters via a Valid/Ack handshake.
// Optional WAIT_ACK abort with a sticky Err flag is enabled by defining MUX16_RR_SCHED_TIMEOUT_EN.
module mux16_rr_sched #(
    parameter int SETTLE_CYC = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [0:15] Req,
    input  logic        Fin,
    input  logic        Ack,
    output logic [3:0]  S,
    output logic [0:15] Gnt,
    output logic        Q,
    output logic        Valid,
    output logic        Busy,
    output logic        Err,
    output logic [1:0]  dbg_state
);

    // Handshake: Valid rises with a fresh Q and stays high, with Q/S/Gnt frozen,
    // until Ack is seen at a rising edge while Valid=1; Ack at any other time is ignored.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        SAMPLE   = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("mux16_rr_sched: SETTLE_CYC or TIMEOUT out of range");
    end

    state_t     state;
    logic [3:0] last;
    logic [3:0] scnt;
    logic [3:0] pick;
    logic [3:0] idx;
    logic       found;

`ifdef MUX16_RR_SCHED_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_r;
    assign Err = err_r;
`else
    assign Err = 1'b0;
`endif

    assign dbg_state = state;

    // Search starts just past the last served index, so it becomes lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        for (int k = 1; k <= 16; k++) begin
            idx = last + 4'(k);
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            last  <= 4'd15;
            scnt  <= '0;
            S     <= '0;
            Gnt   <= '0;
            Q     <= 1'b0;
            Valid <= 1'b0;
            Busy  <= 1'b0;
`ifdef MUX16_RR_SCHED_TIMEOUT_EN
            tcnt  <= '0;
            err_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        S     <= pick;
                        Gnt   <= 16'h8000 >> pick;
                        Busy  <= 1'b1;
                        scnt  <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (scnt == 4'(SETTLE_CYC - 1)) begin
                        state <= SAMPLE;
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    Q     <= Fin;
                    Valid <= 1'b1;
`ifdef MUX16_RR_SCHED_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    // Ack wins over a timeout expiring in the same cycle.
                    if (Ack && Valid) begin
                        Valid <= 1'b0;
                        Gnt   <= '0;
                        Busy  <= 1'b0;
                        last  <= S;
                        state <= IDLE;
`ifdef MUX16_RR_SCHED_TIMEOUT_EN
                    end else if (tcnt == 8'(TIMEOUT - 1)) begin
                        Valid <= 1'b0;
                        Gnt   <= '0;
                        Busy  <= 1'b0;
                        last  <= S;
                        err_r <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
